nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit addition by time-multiplexing one 4-bit ripple adder slice over successive nibbles, from LSB to MSB. It latches the operands on a start/ready handshake, feeds one nibble per clock with the carry registered between nibbles, and reports the result with a one-cycle done pulse. It trades latency for area in front of wide accumulate paths that share a single 4-bit adder.

---
 rtl/nibble_adder_pkg.sv | 13 +
 rtl/nibble_adder.sv | 25 ++
 rtl/nibble_serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: the FSM state
// encoding and the width of the shared adder slice.
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

endpackage : nibble_adder_pkg

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice, time-shared by the
// nibble-serial controller for every nibble of a wide addition.
module nibble_adder
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic [NIB_W:0] carry;

  always_comb begin
    carry[0] = cin_i;
    sum_o    = '0;
    for (int i = 0; i < NIB_W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[NIB_W];
  end

endmodule : nibble_adder

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit slice, processing one nibble per
// clock from LSB to MSB with the inter-nibble carry held in a register.
module nibble_serial_adder_ctrl
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = ($clog2(NIBBLES) > 1) ? $clog2(NIBBLES) : 1;

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  sadd_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  logic             last_nib;

  nibble_adder u_slice (
    .a_i    (a_sh_q[NIB_W-1:0]),
    .b_i    (b_sh_q[NIB_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

  // Each slice result enters at the MSB end, so after NIBBLES passes the
  // first (least significant) nibble has reached bit 0.
  always_comb begin
    sum_d                    = sum_q >> NIB_W;
    sum_d[WIDTH-1 -: NIB_W]  = nib_sum;
  end

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIB_W;
          b_sh_q  <= b_sh_q >> NIB_W;
          sum_q   <= sum_d;
          carry_q <= nib_cout;
          if (last_nib) begin
            // Counter is left at its final value; it reloads on the next accept.
            cout_q  <= nib_cout;
            state_q <= DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed cases on a 16-bit instance plus randomized
// regression on 4/8/16/32-bit instances against a plain a+b+cin model.
module tb_nibble_serial_adder_ctrl;

  localparam int RAND_OPS = 250;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Directed 16-bit instance with its own reset
  logic        rst_n;
  logic        rst_d_n;
  logic        d_start, d_cin, d_ready, d_busy, d_done, d_cout;
  logic [15:0] d_a, d_b, d_sum;

  nibble_serial_adder_ctrl #(.WIDTH(16)) u_dir (
    .clk   (clk),
    .rst_n (rst_d_n),
    .start (d_start),
    .a     (d_a),
    .b     (d_b),
    .cin   (d_cin),
    .ready (d_ready),
    .busy  (d_busy),
    .done  (d_done),
    .sum   (d_sum),
    .cout  (d_cout)
  );

  // Called at a negedge with the DUT ready; returns at the negedge where done is seen.
  task automatic dir_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic [16:0] expv, input bit junk);
    int lat;
    int busy_cnt;
    d_start = 1'b1; d_a = av; d_b = bv; d_cin = cv;
    @(negedge clk);
    d_start = 1'b0;
    d_a = 16'($urandom); d_b = 16'($urandom); d_cin = 1'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!d_done && lat <= 8) begin
      if (d_busy) busy_cnt++;
      if (junk) begin
        d_start = 1'b1; d_a = 16'h0F0F; d_b = 16'h0101;
      end
      @(negedge clk);
      lat++;
    end
    d_start = 1'b0;
    check("dir_latency", lat, 5);
    check("dir_busy_cycles", busy_cnt, 4);
    check("dir_result", {d_cout, d_sum}, expv);
    check("dir_ready_at_done", d_ready, 1'b1);
  endtask

  // Randomized instances, one per width
  for (genvar g = 0; g < 4; g++) begin : g_rand
    localparam int W   = 4 << g;
    localparam int NIB = W / 4;
    logic         start_r, cin_r, ready_w, busy_w, done_w, cout_w;
    logic [W-1:0] a_r, b_r, sum_w;
    bit           fin = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_r),
      .a     (a_r),
      .b     (b_r),
      .cin   (cin_r),
      .ready (ready_w),
      .busy  (busy_w),
      .done  (done_w),
      .sum   (sum_w),
      .cout  (cout_w)
    );

    initial begin : run
      logic [W:0]   exp_v;
      logic [W-1:0] na, nb;
      logic         ncin;
      int           lat, busy_cnt;
      bit           b2b;
      start_r = 1'b0; a_r = '0; b_r = '0; cin_r = 1'b0;
      @(negedge clk);
      while (!rst_n) @(negedge clk);
      b2b = 1'b0;
      for (int op = 0; op < RAND_OPS; op++) begin
        if (!b2b) check("rand_ready_idle", ready_w, 1'b1);
        na    = W'($urandom);
        nb    = W'($urandom);
        ncin  = 1'($urandom);
        exp_v = {1'b0, na} + {1'b0, nb} + {{W{1'b0}}, ncin};
        start_r = 1'b1; a_r = na; b_r = nb; cin_r = ncin;
        @(negedge clk);
        start_r = 1'b0; a_r = W'($urandom); b_r = W'($urandom); cin_r = 1'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!done_w && lat <= NIB + 3) begin
          if (busy_w) busy_cnt++;
          start_r = ($urandom_range(0, 3) == 0);
          a_r = W'($urandom);
          @(negedge clk);
          lat++;
        end
        start_r = 1'b0;
        check("rand_latency", lat, NIB + 1);
        check("rand_busy_cycles", busy_cnt, NIB);
        check("rand_result", {cout_w, sum_w}, exp_v);
        check("rand_busy_at_done", busy_w, 1'b0);
        b2b = ($urandom_range(0, 1) == 1);
        if (!b2b) begin
          @(negedge clk);
          check("rand_done_pulse", done_w, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          check("rand_sum_held", {cout_w, sum_w}, exp_v);
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    int  n_done;
    bit  all_fin;
    rst_n = 1'b0; rst_d_n = 1'b0;
    d_start = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", d_ready, 1'b1);
    check("reset_busy", d_busy, 1'b0);
    check("reset_done", d_done, 1'b0);
    check("reset_sum", d_sum, 16'h0000);
    check("reset_cout", d_cout, 1'b0);
    rst_n = 1'b1; rst_d_n = 1'b1;
    @(negedge clk);

    dir_op(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 1'b0);
    @(negedge clk);
    check("dir_pulse_one_cycle", d_done, 1'b0);
    dir_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    @(negedge clk);
    dir_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0);
    dir_op(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    @(negedge clk);

    // Start asserted throughout RUN with different operands must be ignored
    dir_op(16'h1111, 16'h2222, 1'b1, 17'h03334, 1'b1);
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_done) n_done++;
    end
    check("dir_no_second_done", n_done, 0);
    check("dir_result_kept", {d_cout, d_sum}, 17'h03334);

    // Reset during the second RUN cycle aborts the add
    d_start = 1'b1; d_a = 16'hAAAA; d_b = 16'h5555; d_cin = 1'b0;
    @(negedge clk);
    d_start = 1'b0;
    @(negedge clk);
    rst_d_n = 1'b0;
    @(negedge clk);
    rst_d_n = 1'b1;
    check("abort_ready", d_ready, 1'b1);
    check("abort_busy", d_busy, 1'b0);
    check("abort_sum", d_sum, 16'h0000);
    check("abort_cout", d_cout, 1'b0);
    n_done = 0;
    repeat (6) begin
      if (d_done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    dir_op(16'h8001, 16'h7FFF, 1'b0, 17'h10000, 1'b0);

    all_fin = 1'b0;
    for (int i = 0; i < 40000 && !all_fin; i++) begin
      @(negedge clk);
      all_fin = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin;
    end
    check("rand_complete", all_fin, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nibble_serial_adder_ctrl
